// File: rtl/alu_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer.
package alu_pkg;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/nibble_add4.sv
// Combinational 4-bit ripple-carry adder; c3 is the carry into bit 3 for overflow detection.
module nibble_add4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic       c3
);
  logic [3:0] lo;
  logic [1:0] hi;

  always_comb begin
    lo      = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b000, cin};
    c3      = lo[3];
    hi      = {1'b0, a[3]} + {1'b0, b[3]} + {1'b0, c3};
    sum     = {hi[0], lo[2:0]};
    cout    = hi[1];
  end
endmodule

// File: rtl/nibble_serial_addsub_seq.sv
// W-bit add/subtract computed one nibble per cycle, LSB nibble first, through one shared 4-bit adder.
// Optional saturation on signed overflow: define ALU_SEQ_SAT_EN.
module nibble_serial_addsub_seq
  import alu_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        op,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  output logic                        busy,
  output logic                        done,
  output logic [NIBBLE_W*NIBBLES-1:0] result,
  output logic                        flag_n,
  output logic                        flag_z,
  output logic                        flag_c,
  output logic                        flag_v
);
  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int KW = $clog2(NIBBLES);

  state_t state, state_nx;

  // Operands shift right so the active slice is always at [3:0]; completed
  // sum nibbles shift in from the top of work.
  logic [W-1:0]        opa, opb;
  logic [W-NIBBLE_W-1:0] work;
  logic                carry, zacc;
  logic [KW-1:0]       k;

  logic [3:0]   sum;
  logic         cout, c3;
  logic         accept, last, ovf, zero_nx, zfin;
  logic [W-1:0] word_nx, res_nx;

  nibble_add4 u_add (
    .a    (opa[3:0]),
    .b    (opb[3:0]),
    .cin  (carry),
    .sum  (sum),
    .cout (cout),
    .c3   (c3)
  );

  always_comb begin
    accept  = (state == IDLE) && start;
    last    = (k == KW'(NIBBLES - 1));
    word_nx = {sum, work};
    zero_nx = zacc && (sum == 4'h0);
    ovf     = c3 ^ cout;
`ifdef ALU_SEQ_SAT_EN
    // opa[3] holds the latched A sign bit once the top slice is active.
    if (ovf) begin
      res_nx = opa[3] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      zfin   = 1'b0;
    end else begin
      res_nx = word_nx;
      zfin   = zero_nx;
    end
`else
    res_nx = word_nx;
    zfin   = zero_nx;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa    <= '0;
      opb    <= '0;
      work   <= '0;
      carry  <= 1'b0;
      zacc   <= 1'b0;
      k      <= '0;
      result <= '0;
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
    end else if (accept) begin
      opa   <= a;
      opb   <= b ^ {W{op}};
      carry <= (op == OP_SUB);
      k     <= '0;
      zacc  <= 1'b1;
    end else if (state == RUN) begin
      opa   <= opa >> NIBBLE_W;
      opb   <= opb >> NIBBLE_W;
      work  <= word_nx[W-1:NIBBLE_W];
      carry <= cout;
      zacc  <= zero_nx;
      k     <= last ? '0 : k + KW'(1);
      if (last) begin
        result <= res_nx;
        flag_c <= cout;
        flag_v <= ovf;
        flag_n <= res_nx[W-1];
        flag_z <= zfin;
      end
    end
  end
endmodule

// File: tb/tb_nibble_serial_addsub_seq.sv
// Self-checking bench: word-level arithmetic model compared every cycle, plus directed literal vectors.
module tb_nibble_serial_addsub_seq;
  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, flag_n, flag_z, flag_c, flag_v;
  logic [W-1:0] result;

  int nchecks = 0;
  int nerrors = 0;

  nibble_serial_addsub_seq #(.NIBBLES(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result),
    .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word-level model: phase 0 idle, 1..N busy computing, N+1 done pulse.
  int           p;
  logic [W-1:0] m_res, pend_res;
  logic [3:0]   m_flg, pend_flg;

  function automatic logic [W+3:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic o);
    logic [W-1:0] yy, r;
    logic [W:0]   s;
    logic         c, v;
    yy = o ? ~y : y;
    s  = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, o};
    r  = s[W-1:0];
    c  = s[W];
    v  = (x[W-1] == yy[W-1]) && (r[W-1] != x[W-1]);
`ifdef ALU_SEQ_SAT_EN
    if (v) r = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    return {r, r[W-1], (r == '0), c, v};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p = 0; m_res = '0; m_flg = '0;
    end else if (p == 0) begin
      if (start) begin
        {pend_res, pend_flg} = ref_op(a, b, op);
        p = 1;
      end
    end else if (p <= N) begin
      p = p + 1;
      if (p == N + 1) begin
        m_res = pend_res; m_flg = pend_flg;
      end
    end else begin
      p = 0;
    end
  end

  always @(negedge clk) begin
    chk("busy",   busy, (p != 0));
    chk("done",   done, (p == N + 1));
    chk("result", result, m_res);
    chk("flags",  {flag_n, flag_z, flag_c, flag_v}, m_flg);
  end

  // Issue one op, wait (bounded) for done, check latency and literal outputs.
  task automatic run_op(input string name, input logic [W-1:0] xa, input logic [W-1:0] xb,
                        input logic xo, input logic [W-1:0] er, input logic [3:0] ef);
    int cnt;
    @(negedge clk);
    a = xa; b = xb; op = xo; start = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      cnt++;
    end while (!done && cnt < 3 * N);
    if (!done) chk({name, "_timeout"}, 0, 1);
    else begin
      chk({name, "_latency"}, cnt - 1, N);
      chk({name, "_result"}, result, er);
      chk({name, "_nzcv"}, {flag_n, flag_z, flag_c, flag_v}, ef);
    end
    @(negedge clk);
  endtask

  int ndone;

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_result", result, 0);
    chk("reset_flags", {flag_n, flag_z, flag_c, flag_v}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("add", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 4'b0000);
`ifdef ALU_SEQ_SAT_EN
    run_op("ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h7FFF, 4'b0001);
`else
    run_op("ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b1001);
`endif
    run_op("sub_eq", 16'h0005, 16'h0005, 1'b1, 16'h0000, 4'b0110);
    run_op("borrow", 16'h0000, 16'h0001, 1'b1, 16'hFFFF, 4'b1000);
    chk("hold_result", result, 16'hFFFF);

    // Starts during RUN and DONE are dropped; start in the next IDLE cycle is taken.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; op = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); a = 16'hFFFF; b = 16'hFFFF; op = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 3 * N && ndone == 0; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("ign_done_seen", ndone, 1);
    chk("ign_result", result, 16'h3333);
    chk("ign_nzcv", {flag_n, flag_z, flag_c, flag_v}, 4'b0000);
    a = 16'h4444; b = 16'h4444; op = 1'b0; start = 1'b1;
    @(negedge clk);
    chk("ign_idle", busy, 0);
    a = 16'h8000; b = 16'h0001; op = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("idle_accept", busy, 1);
    ndone = 0;
    for (int i = 0; i < 3 * N && ndone == 0; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("acc_done_seen", ndone, 1);
`ifdef ALU_SEQ_SAT_EN
    chk("acc_result", result, 16'h8000);
    chk("acc_nzcv", {flag_n, flag_z, flag_c, flag_v}, 4'b1011);
`else
    chk("acc_result", result, 16'h7FFF);
    chk("acc_nzcv", {flag_n, flag_z, flag_c, flag_v}, 4'b0011);
`endif
    @(negedge clk);

    // Reset during slice 2 of RUN.
    @(negedge clk);
    a = 16'h1234; b = 16'h0FFF; op = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {flag_n, flag_z, flag_c, flag_v}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 2 * N + 4; i++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    chk("rst_no_done", ndone, 0);

    run_op("post_rst", 16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 4'b1000);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/nibble_serial_addsub_seq.md
# nibble_serial_addsub_seq

Multi-cycle sequencer that performs W-bit add/subtract by time-multiplexing one 4-bit ripple-carry nibble adder, least significant nibble first, and chains the carry between cycles. It sits between a requester issuing single-operation commands and the 4-bit adder datapath. It provides a start/busy/done handshake and registered N/Z/C/V flags for the full word. It trades latency for area in the ALU.

## Interface
- NIBBLES, default 4: number of 4-bit slices; word width W = 4*NIBBLES; legal range 2..16.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- op  in  1  0 = A+B, 1 = A-B.
- a  in  W  operand A, captured on accepted start.
- b  in  W  operand B, captured on accepted start.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.
- result  out  W  registered result; updates only at completion.
- flag_n, flag_z, flag_c, flag_v  out  1 each  registered negative, zero, carry, overflow flags for the full word.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on start=1: latch a; latch b XOR {W{op}}; carry register ← op; slice index k ← 0; zero accumulator ← 1.
  - RUN: the nibble adder receives A[4k+3:4k], B'[4k+3:4k], and the carry. Sum nibble goes into working register slice k. Carry register ← nibble cout. zero accumulator &= (sum nibble == 0). k increments.
  - RUN→DONE on the edge that processes k = NIBBLES-1. On that edge: result ← working word; flag_c ← final cout; flag_v ← carry-into-bit3 XOR cout of the top nibble; flag_n ← result MSB; flag_z ← accumulated zero.
  - DONE→IDLE unconditionally; done=1 only in DONE.
- Subtraction is two's complement. flag_c=1 means no borrow.
- start while busy=1 (including DONE) is ignored and not queued. a/b/op changes during RUN have no effect.
- Overflow wraps modulo 2^W unless saturation is configured.
- Reset: IDLE; busy, done, result, and all flags are 0; working registers and k are 0. Reset mid-RUN abandons the operation, and no done follows release.

## Timing
- Accepted start at edge E0. Nibble k is written at edge E(k+1). done and updated result/flags are visible after edge E(NIBBLES), for exactly one cycle of done.
- Latency from accept to done is NIBBLES cycles. Minimum start-to-start spacing is NIBBLES+2 cycles.
- result and flags hold their values from completion until the next completion or reset.
- busy rises the cycle after an accepted start and falls the cycle after done.

## Configuration
- Macro ALU_SEQ_SAT_EN.
- Defined: when the final V=1, result is replaced by the signed limit. Use 0111…1 if the latched A MSB is 0, otherwise 1000…0. flag_n and flag_z reflect the saturated value. flag_v and flag_c still report the raw arithmetic.
- Undefined: no saturation logic; result is the wrapped sum.

## Structure
- Shared package alu_pkg: op encodings OP_ADD=1'b0 and OP_SUB=1'b1, FSM state encoding, and the nibble width constant 4.
- One sub-module: nibble_add4, a combinational 4-bit adder. Outputs are sum, cout, and c3 (carry into bit 3). Instantiated once.
- FSM, slice counter, operand/working shift registers, and flag logic live in the top module.

## Test plan
- Add, NIBBLES=4: a=0x1234, b=0x0FFF, op=0. Required: done 4 cycles after accept, result=0x2233, N0 Z0 C0 V0.
- Signed overflow: 0x7FFF+0x0001. Required: 0x8000, N1 V1 C0. With ALU_SEQ_SAT_EN: result 0x7FFF, N0, V1.
- Subtract equal: 0x0005-0x0005. Required: 0x0000, Z1 C1 V0 N0.
- Borrow: 0x0000-0x0001. Required: 0xFFFF, N1 C0 V0.
- start pulsed during RUN and during DONE with different operands. Required: exactly one done carrying the first operation's result; a start in the following IDLE cycle is accepted.
- rst_n low during RUN slice 2. Required: busy, done, result, and flags immediately 0; no done after release; the next operation completes normally.
